// File: rtl/dvs_event_reader.sv
// Walks a packed DVS block held in BRAM word by word and emits one event per
// non-empty colour half-word on a valid/ready stream, with per-block status.
module dvs_event_reader #(
  parameter int WORDS_PER_BLOCK = 2048,
  parameter int WORDS_PER_ROW   = 64
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        line_ready,
  input  logic [6:0]  row_base,
  input  logic        new_frame,
  output logic [31:0] bram_addr,
  output logic        bram_clk,
  output logic        bram_rst,
  output logic [3:0]  bram_we,
  output logic        bram_en,
  input  logic [31:0] bram_rddata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [6:0]  evt_x,
  output logic [6:0]  evt_y,
  output logic        evt_pol,
  output logic        busy,
  output logic        block_done,
  output logic        missed_block,
  output logic        code_err,
  output logic [15:0] evt_count
);
  localparam int AW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [AW-1:0] W_LAST = AW'(WORDS_PER_BLOCK - 1);
  localparam logic [31:0]   WPR    = 32'(WORDS_PER_ROW);

  typedef enum logic [2:0] {IDLE, RD, CAP, H0, H1, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] w_q, w_d;
  logic [6:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;  // {colour1, colour0} of the current word
  logic [15:0]   cnt_q, cnt_d;
  logic          done_q, missed_q, err_q;

  logic [1:0]  colour;
  logic        in_half, has_evt, bad_code, xfer, advance, start;
  logic [31:0] w_ext;
  logic        unused_rd;

  assign in_half  = (state_q == H0) || (state_q == H1);
  assign colour   = (state_q == H1) ? col_q[3:2] : col_q[1:0];
  assign has_evt  = in_half && ((colour == 2'b01) || (colour == 2'b10));
  assign bad_code = in_half && (colour == 2'b11);
  assign xfer     = has_evt && evt_ready;
  assign advance  = !has_evt || evt_ready;
  assign start    = (state_q == IDLE) && line_ready && !new_frame;
  assign w_ext    = 32'(w_q);

  // Reference and pixel fields are not needed to produce events.
  assign unused_rd = ^{bram_rddata[31:24], bram_rddata[21:8], bram_rddata[5:0]};

  always_ff @(posedge pclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_frame) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (line_ready) state_d = RD;
        RD:      state_d = CAP;
        CAP:     state_d = H0;
        H0:      if (advance) state_d = H1;
        H1:      if (advance) state_d = (w_q == W_LAST) ? DONE : RD;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    w_d   = w_q;
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (start) begin
      w_d   = '0;
      row_d = row_base;
      cnt_d = '0;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (state_q == CAP) col_d = {bram_rddata[23:22], bram_rddata[7:6]};
    if ((state_q == H1) && (state_d == RD)) w_d = w_q + AW'(1);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      w_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      w_q    <= w_d;
      row_q  <= row_d;
      col_q  <= col_d;
      cnt_q  <= cnt_d;
      done_q <= (state_q == DONE) && !new_frame;
      if (line_ready && (state_q != IDLE)) missed_q <= 1'b1;
      if (bad_code) err_q <= 1'b1;
    end
  end

  always_comb begin
    bram_en   = (state_q == RD);
    busy      = (state_q != IDLE);
    evt_valid = has_evt;
    evt_pol   = has_evt && (colour == 2'b01);
    evt_x     = 7'(((w_ext % WPR) << 1) | 32'(state_q == H1));
    evt_y     = row_q + 7'(w_ext / WPR);
  end

  assign bram_addr    = w_ext;
  assign bram_clk     = pclk;
  assign bram_rst     = reset;
  assign bram_we      = 4'b0000;
  assign block_done   = done_q;
  assign missed_block = missed_q;
  assign code_err     = err_q;
  assign evt_count    = cnt_q;
endmodule

// File: tb/tb_dvs_event_reader.sv
// Bench for dvs_event_reader: table of single-event blocks, hand-written
// stall/miss/abort/reset sequences and a random block against a queue model.
module tb_dvs_event_reader;
  localparam int NW  = 2048;
  localparam int WPR = 64;

  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic       pol;
  } evt_t;

  typedef struct {
    int          widx;
    logic [31:0] word;
    logic [6:0]  rb;
    int          n_evt;
    logic [6:0]  x0;
    logic [6:0]  y0;
    logic        pol0;
  } vec_t;

  logic        pclk = 1'b0;
  logic        reset, line_ready, new_frame;
  logic [6:0]  row_base;
  logic [31:0] bram_addr, bram_rddata;
  logic        bram_clk, bram_rst, bram_en;
  logic [3:0]  bram_we;
  logic        evt_valid, evt_ready, evt_pol;
  logic [6:0]  evt_x, evt_y;
  logic        busy, block_done, missed_block, code_err;
  logic [15:0] evt_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:NW-1];
  evt_t        exp_q[$];
  int          n_model;
  bit          model_err;

  int   ready_mode = 0;  // 0: ready held high, 1: random, 2: manual_ready
  logic manual_ready = 1'b0;
  logic rnd_bit = 1'b1;
  int   cyc = 0;
  int   start_cyc = 0;

  int         valid_total = 0, xfer_total = 0;
  int         valid_base = 0, xfer_base = 0;
  bit         first_seen = 1'b0;
  logic [6:0] first_x = '0, first_y = '0;
  logic       first_pol = 1'b0;
  bit         prev_hold = 1'b0;

  vec_t tbl [4];

  dvs_event_reader dut (
    .pclk        (pclk),
    .reset       (reset),
    .line_ready  (line_ready),
    .row_base    (row_base),
    .new_frame   (new_frame),
    .bram_addr   (bram_addr),
    .bram_clk    (bram_clk),
    .bram_rst    (bram_rst),
    .bram_we     (bram_we),
    .bram_en     (bram_en),
    .bram_rddata (bram_rddata),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_x       (evt_x),
    .evt_y       (evt_y),
    .evt_pol     (evt_pol),
    .busy        (busy),
    .block_done  (block_done),
    .missed_block(missed_block),
    .code_err    (code_err),
    .evt_count   (evt_count)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc++;

  always @(posedge pclk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign evt_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_bit : manual_ready;

  // Synchronous BRAM: data appears the cycle after the enable.
  always @(posedge pclk) begin
    if (bram_en) bram_rddata <= mem[bram_addr[10:0]];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;
  endfunction

  // Expected event stream derived directly from the word format and geometry.
  function automatic void build_expected(input logic [6:0] rb);
    exp_q.delete();
    model_err = 1'b0;
    for (int w = 0; w < NW; w++) begin
      for (int h = 0; h < 2; h++) begin
        logic [1:0] c;
        c = (h == 1) ? mem[w][23:22] : mem[w][7:6];
        if (c == 2'b01 || c == 2'b10) begin
          evt_t e;
          e.x   = 7'(2 * (w % WPR) + h);
          e.y   = 7'((int'(rb) + w / WPR) % 128);
          e.pol = (c == 2'b01);
          exp_q.push_back(e);
        end else if (c == 2'b11) begin
          model_err = 1'b1;
        end
      end
    end
    n_model = exp_q.size();
  endfunction

  always @(negedge pclk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_evt_valid", evt_valid, 1);
      if (evt_valid) begin
        valid_total++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_evt: got evt x=%0d y=%0d, expected no event", evt_x, evt_y);
        end else begin
          check("evt_x", evt_x, exp_q[0].x);
          check("evt_y", evt_y, exp_q[0].y);
          check("evt_pol", evt_pol, exp_q[0].pol);
          if (evt_ready) void'(exp_q.pop_front());
        end
        if (evt_ready) begin
          if (xfer_total == xfer_base) begin
            first_seen = 1'b1;
            first_x    = evt_x;
            first_y    = evt_y;
            first_pol  = evt_pol;
          end
          xfer_total++;
        end
      end
      prev_hold = evt_valid && !evt_ready && !new_frame;
      if (bram_en) check("bram_addr_range", 32'(bram_addr < 32'(NW)), 1);
    end
  end

  task automatic start_block(input logic [6:0] rb);
    build_expected(rb);
    valid_base = valid_total;
    xfer_base  = xfer_total;
    first_seen = 1'b0;
    @(posedge pclk);
    #1;
    line_ready = 1'b1;
    row_base   = rb;
    start_cyc  = cyc;
    @(posedge pclk);
    #1;
    line_ready = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge pclk);
      if (block_done) begin
        lat = cyc - start_cyc;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL block_done_timeout: no block_done within %0d cycles", bound);
    end else begin
      @(negedge pclk);
      check("block_done_pulse", block_done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic wait_valid(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge pclk);
      if (evt_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_evt_valid: evt_valid=0 after %0d cycles, expected 1", bound);
    end
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1;
    reset = 1'b1;
    line_ready = 1'b0;
    new_frame = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("bram_rst_follows", bram_rst, 1);
    check("bram_clk_follows", bram_clk, 0);
    @(posedge pclk);
    #1;
    reset = 1'b0;
    @(negedge pclk);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_x", evt_x, 0);
    check("rst_evt_y", evt_y, 0);
    check("rst_evt_pol", evt_pol, 0);
    check("rst_busy", busy, 0);
    check("rst_block_done", block_done, 0);
    check("rst_missed", missed_block, 0);
    check("rst_code_err", code_err, 0);
    check("rst_evt_count", evt_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [6:0] rb;

    tbl[0] = '{0,    32'h0000_0000, 7'd88,  0, 7'd0,   7'd0,  1'b0};
    tbl[1] = '{65,   32'h0040_0080, 7'd88,  2, 7'd2,   7'd89, 1'b0};
    tbl[2] = '{2047, 32'h0040_0000, 7'd120, 1, 7'd127, 7'd23, 1'b1};
    tbl[3] = '{1000, 32'h0080_0040, 7'd5,   2, 7'd80,  7'd20, 1'b1};

    reset = 1'b1;
    line_ready = 1'b0;
    new_frame = 1'b0;
    row_base = '0;
    clear_mem();
    repeat (3) @(posedge pclk);
    do_reset();

    // Single-event blocks with ready held high: timing, decode and geometry.
    ready_mode = 0;
    for (int t = 0; t < 4; t++) begin
      clear_mem();
      mem[tbl[t].widx] = tbl[t].word;
      start_block(tbl[t].rb);
      wait_done(9000, lat);
      check("tbl_latency", lat, 8194);
      check("tbl_evt_count", evt_count, tbl[t].n_evt);
      check("tbl_transfers", xfer_total - xfer_base, tbl[t].n_evt);
      check("tbl_valid_cycles", valid_total - valid_base, tbl[t].n_evt);
      check("tbl_queue_left", exp_q.size(), 0);
      check("tbl_first_seen", 32'(first_seen), 32'(tbl[t].n_evt > 0));
      if (tbl[t].n_evt > 0) begin
        check("tbl_first_x", first_x, tbl[t].x0);
        check("tbl_first_y", first_y, tbl[t].y0);
        check("tbl_first_pol", first_pol, tbl[t].pol0);
      end
      check("tbl_code_err", code_err, 0);
    end

    // Random words and random back-pressure against the model.
    for (int w = 0; w < NW; w++) mem[w] = $urandom();
    rb = 7'($urandom_range(0, 127));
    ready_mode = 1;
    start_block(rb);
    wait_done(30000, lat);
    check("rnd_evt_count", evt_count, (n_model > 65535) ? 65535 : n_model);
    check("rnd_transfers", xfer_total - xfer_base, n_model);
    check("rnd_queue_left", exp_q.size(), 0);
    check("rnd_code_err", code_err, 32'(model_err));
    check("rnd_missed", missed_block, 0);
    do_reset();

    // Event stalled for 10 cycles, then exactly one transfer.
    clear_mem();
    mem[10] = 32'h0000_0040;
    ready_mode = 2;
    manual_ready = 1'b0;
    start_block(7'd33);
    wait_valid(200);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge pclk);
      check("stall_valid", evt_valid, 1);
      check("stall_x", evt_x, 20);
      check("stall_y", evt_y, 33);
      check("stall_pol", evt_pol, 1);
    end
    @(posedge pclk);
    #1 manual_ready = 1'b1;
    @(posedge pclk);
    #1 manual_ready = 1'b0;
    wait_done(9000, lat);
    check("stall_transfers", xfer_total - xfer_base, 1);
    check("stall_evt_count", evt_count, 1);
    @(negedge pclk);
    check("evt_count_holds", evt_count, 1);

    // Second line_ready mid-block is missed; the block still completes.
    clear_mem();
    mem[300] = 32'h0040_0000;
    ready_mode = 0;
    start_block(7'd40);
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (bram_en && bram_addr == 32'd100) break;
    end
    check("miss_at_word", bram_addr, 100);
    @(posedge pclk);
    #1;
    line_ready = 1'b1;
    row_base = 7'd3;
    @(posedge pclk);
    #1 line_ready = 1'b0;
    @(negedge pclk);
    check("missed_set", missed_block, 1);
    wait_done(9000, lat);
    check("miss_latency", lat, 8194);
    check("miss_evt_count", evt_count, 1);
    check("miss_queue_left", exp_q.size(), 0);

    // Abort while an event is pending at word 500.
    clear_mem();
    mem[500] = 32'h0000_0080;
    ready_mode = 2;
    manual_ready = 1'b0;
    start_block(7'd10);
    wait_valid(2200);
    check("abort_addr", bram_addr, 500);
    check("abort_x", evt_x, 104);
    @(posedge pclk);
    #1 new_frame = 1'b1;
    @(posedge pclk);
    #1 new_frame = 1'b0;
    @(negedge pclk);
    check("abort_valid", evt_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_bram_en", bram_en, 0);
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", block_done, 0);
      check("abort_idle", busy, 0);
      @(negedge pclk);
    end

    // new_frame together with line_ready: no block starts.
    @(posedge pclk);
    #1;
    line_ready = 1'b1;
    new_frame = 1'b1;
    @(posedge pclk);
    #1;
    line_ready = 1'b0;
    new_frame = 1'b0;
    @(negedge pclk);
    check("nf_prio_busy", busy, 0);
    check("nf_prio_bram_en", bram_en, 0);

    // Colour 11 sets code_err and emits nothing.
    clear_mem();
    mem[7] = 32'h00C0_00C0;
    ready_mode = 0;
    check("err_before", code_err, 0);
    start_block(7'd0);
    wait_done(9000, lat);
    check("err_latency", lat, 8194);
    check("err_set", code_err, 1);
    check("err_evt_count", evt_count, 0);
    check("err_no_valid", valid_total - valid_base, 0);

    // Reset wins over a handshake completing on the same edge.
    clear_mem();
    mem[0] = 32'h0000_0040;
    ready_mode = 2;
    manual_ready = 1'b0;
    start_block(7'd60);
    wait_valid(50);
    @(posedge pclk);
    #1;
    reset = 1'b1;
    manual_ready = 1'b1;
    @(posedge pclk);
    #1;
    reset = 1'b0;
    manual_ready = 1'b0;
    @(negedge pclk);
    check("rstpend_valid", evt_valid, 0);
    check("rstpend_busy", busy, 0);
    check("rstpend_count", evt_count, 0);
    check("rstpend_missed", missed_block, 0);
    check("rstpend_err", code_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dvs_event_reader.md
DVS_EVENT_READER -- requirements
Module: dvs_event_reader

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter WORDS_PER_BLOCK SHALL default to 2048 and gives the number of packed 32-bit words per block.
REQ-003 Parameter WORDS_PER_ROW SHALL default to 64 and gives the number of words per 128-pixel row.
REQ-004 pclk  in  1  is the sole clock; all logic is on its rising edge.
REQ-005 reset  in  1  is the synchronous, active-high reset.
REQ-006 line_ready  in  1  is a one-cycle-or-longer pulse meaning a packed block is present in BRAM.
REQ-007 row_base  in  7  is the image row of block word 0, sampled when a block starts.
REQ-008 new_frame  in  1  is an abort request; the current block is discarded.
REQ-009 bram_addr  out  32  is the word index into the block buffer.
REQ-010 bram_clk  out  1  SHALL equal pclk; bram_rst SHALL equal reset; bram_we  out  4 SHALL be constant 4'b0000.
REQ-011 bram_en  out  1  is the read enable; bram_rddata  in  32  is the read data, valid one cycle after bram_en.
REQ-012 evt_valid  out  1, evt_ready  in  1, evt_x  out  7, evt_y  out  7, evt_pol  out  1 (1 = positive) form the event stream.
REQ-013 busy  out  1; block_done  out  1 (pulse); missed_block  out  1 (sticky); code_err  out  1 (sticky); evt_count  out  16.

Function
REQ-014 Word format SHALL be: [31:24] ref1, [23:22] colour1, [21:16] pix1, [15:8] ref0, [7:6] colour0, [5:0] pix0.
REQ-015 Half 0 SHALL be column 2*(w mod WORDS_PER_ROW); half 1 SHALL be that column +1.
REQ-016 Row SHALL be (row_base_latched + w / WORDS_PER_ROW) mod 128.
REQ-017 Colour decoding: 01 SHALL emit an event with pol=1, 10 SHALL emit with pol=0, and 00 SHALL emit nothing.
REQ-018 Colour 11 SHALL emit nothing and SHALL set code_err.
REQ-019 The FSM SHALL have the states IDLE, RD, CAP, H0, H1, DONE.
REQ-020 IDLE: when line_ready=1, the FSM SHALL latch row_base, clear evt_count, set busy=1, set w=0 and go to RD.
REQ-021 RD: the block SHALL drive bram_en=1 and bram_addr=w, then go to CAP.
REQ-022 CAP: the block SHALL register bram_rddata into the word register and drive bram_en=0, then go to H0.
REQ-023 H0/H1 with no event: the FSM SHALL advance after one cycle.
REQ-024 H0/H1 with an event: evt_valid=1 SHALL be driven with stable x/y/pol until evt_ready=1, and the FSM SHALL then advance.
REQ-025 Each accepted transfer (evt_valid & evt_ready) SHALL increment evt_count, which saturates at 16'hFFFF.
REQ-026 H1 exit: if w = WORDS_PER_BLOCK-1 the FSM SHALL go to DONE, otherwise it SHALL set w=w+1 and go to RD.
REQ-027 DONE: block_done SHALL be 1 for exactly one cycle, busy SHALL be 0 from the next cycle, and the FSM SHALL return to IDLE.
REQ-028 evt_count SHALL hold its value until the next block start.
REQ-029 Minimum latency: line_ready to the first bram_en is 1 cycle; an all-zero word costs 4 cycles; an all-zero block costs 4*WORDS_PER_BLOCK+2 cycles.
REQ-030 line_ready while busy=1 SHALL be ignored and SHALL set missed_block.
REQ-031 line_ready in the DONE cycle SHALL be treated as missed.
REQ-032 new_frame in any state other than IDLE SHALL force IDLE next cycle with evt_valid=0, bram_en=0, busy=0, and no block_done.
REQ-033 new_frame abort is the only permitted withdrawal of evt_valid.
REQ-034 new_frame together with line_ready SHALL give priority to new_frame, and no block SHALL start.
REQ-035 evt_ready held high continuously SHALL give at most one event per cycle, with no bubbles forced between H0 and H1.
REQ-036 bram_addr SHALL never exceed WORDS_PER_BLOCK-1.

Reset
REQ-037 When reset=1 at a rising edge, the block SHALL return to IDLE.
REQ-038 Reset SHALL clear bram_addr=0, bram_en=0, evt_valid=0, evt_x=0, evt_y=0, evt_pol=0, busy=0, block_done=0, missed_block=0, code_err=0, evt_count=0.
REQ-039 Reset SHALL take precedence over all other inputs, including a pending handshake.
REQ-040 Sticky flags SHALL clear only on reset.

Verification
REQ-041 The bench SHALL cover this case: all-zero block, row_base=88 -> no evt_valid, block_done exactly 8194 cycles after the line_ready cycle, evt_count=0.
REQ-042 The bench SHALL cover this case: word 65 = 32'h0040_0080 (colour1=01, colour0=10), row_base=88, evt_ready=1 -> events (x=2,y=89,pol=0) then (x=3,y=89,pol=1), evt_count=2.
REQ-043 The bench SHALL cover this case: event pending with evt_ready low for 10 cycles -> evt_valid, x, y, pol stable for all 10 cycles; exactly one transfer.
REQ-044 The bench SHALL cover this case: row_base=120 with event in word 2047 -> y=(120+31) mod 128=23, x=127.
REQ-045 The bench SHALL cover this case: second line_ready at word 100 -> missed_block=1 and the current block completes normally.
REQ-046 The bench SHALL cover this case: new_frame at word 500 with evt_valid=1 -> next cycle IDLE, evt_valid=0, busy=0, no block_done; colour 11 word -> code_err=1 and no event.
